// File: rtl/queue_pair_merge.sv
// Merges din0/din1 into one ordered stream: each pair is a complete din0 transaction, then a complete din1 transaction.
// Beats go through a 2-entry registered FIFO. The accepted-beat path never looks at dout_ready_i.
module queue_pair_merge #(
   parameter int W_DIN0 = 16,
   parameter int W_DIN1 = 16,
   parameter int W_CNT  = 16,
   localparam int WP     = ((W_DIN0 > W_DIN1) ? W_DIN0 : W_DIN1) - 1,
   localparam int W_DOUT = WP + 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [W_DIN0-1:0] din0_data_i,
   input  logic              din0_valid_i,
   output logic              din0_ready_o,
   input  logic [W_DIN1-1:0] din1_data_i,
   input  logic              din1_valid_i,
   output logic              din1_ready_o,
   output logic [W_DOUT-1:0] dout_data_o,
   output logic              dout_valid_o,
   input  logic              dout_ready_i,
   output logic [W_CNT-1:0]  pair_cnt_o
);

   typedef enum logic {S0, S1} state_e;

   state_e              state_q, state_d;
   logic [W_DOUT-1:0]   head_q, head_d;
   logic [W_DOUT-1:0]   tail_q, tail_d;
   logic [1:0]          count_q, count_d;
   logic                valid_q, valid_d;
   logic [W_CNT-1:0]    pairCnt_q, pairCnt_d;

   logic                full;
   logic                accept0, accept1, push, pop, pushEot;
   logic                eot0, eot1;
   logic [W_DOUT-1:0]   pushWord;

   assign eot0 = din0_data_i[W_DIN0-1];
   assign eot1 = din1_data_i[W_DIN1-1];
   assign full = (count_q == 2'd2);

   // Ready comes only from registered state; it is held low while reset is applied.
   assign din0_ready_o = !rst && (state_q == S0) && !full;
   assign din1_ready_o = !rst && (state_q == S1) && !full;

   assign accept0 = din0_valid_i && din0_ready_o;
   assign accept1 = din1_valid_i && din1_ready_o;
   assign push    = accept0 || accept1;
   assign pop     = valid_q && dout_ready_i;
   assign pushEot = (state_q == S0) ? eot0 : eot1;

   // Entry layout: {pair_eot, eot, src, zero-extended payload}
   assign pushWord = (state_q == S0)
      ? {1'b0, eot0, 1'b0, WP'(din0_data_i[W_DIN0-2:0])}
      : {eot1, eot1, 1'b1, WP'(din1_data_i[W_DIN1-2:0])};

   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      pairCnt_d = pairCnt_q;

      if (push && pushEot) begin
         state_d = (state_q == S0) ? S1 : S0;
      end
      if (accept1 && eot1) begin
         pairCnt_d = pairCnt_q + W_CNT'(1);
      end

      // head_q is always the oldest entry, so dout is taken straight from a register.
      case (count_q)
         2'd0: begin
            if (push) begin
               head_d  = pushWord;
               count_d = 2'd1;
            end
         end
         2'd1: begin
            if (push && pop) begin
               head_d = pushWord;
            end else if (push) begin
               tail_d  = pushWord;
               count_d = 2'd2;
            end else if (pop) begin
               count_d = 2'd0;
            end
         end
         default: begin
            if (pop) begin
               head_d  = tail_q;
               count_d = 2'd1;
            end
         end
      endcase

      valid_d = (count_d != 2'd0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= 2'd0;
         valid_q   <= 1'b0;
         pairCnt_q <= '0;
      end else begin
         state_q   <= state_d;
         head_q    <= head_d;
         tail_q    <= tail_d;
         count_q   <= count_d;
         valid_q   <= valid_d;
         pairCnt_q <= pairCnt_d;
      end
   end

   assign dout_data_o  = head_q;
   assign dout_valid_o = valid_q;
   assign pair_cnt_o   = pairCnt_q;

endmodule

// File: tb/tb_queue_pair_merge.sv
// Bench for queue_pair_merge. The reference model tracks the expected output words, the active input and the pair count.
// It derives those from the merge rules using queues, then compares them each cycle.
module tb_queue_pair_merge;

   localparam int W0 = 8;
   localparam int W1 = 16;
   localparam int WC = 4;
   localparam int WP = 15;
   localparam int WD = 18;

   logic          clk = 1'b0;
   logic          rst;
   logic [W0-1:0] din0Data;
   logic          din0Valid;
   logic          din0Ready;
   logic [W1-1:0] din1Data;
   logic          din1Valid;
   logic          din1Ready;
   logic [WD-1:0] doutData;
   logic          doutValid;
   logic          doutReady;
   logic [WC-1:0] pairCnt;

   int testsRun = 0;
   int testsFailed = 0;

   logic [W0-1:0] src0Q[$];
   logic [W1-1:0] src1Q[$];
   logic [WD-1:0] expQ[$];
   int            modelActive;
   int            modelPairs;

   queue_pair_merge #(.W_DIN0(W0), .W_DIN1(W1), .W_CNT(WC)) dut (
      .clk          (clk),
      .rst          (rst),
      .din0_data_i  (din0Data),
      .din0_valid_i (din0Valid),
      .din0_ready_o (din0Ready),
      .din1_data_i  (din1Data),
      .din1_valid_i (din1Valid),
      .din1_ready_o (din1Ready),
      .dout_data_o  (doutData),
      .dout_valid_o (doutValid),
      .dout_ready_i (doutReady),
      .pair_cnt_o   (pairCnt)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance the model.
   task automatic applyStimulus(input bit rstIn, input bit en0, input bit en1, input bit rdy);
      bit            v0, v1, exp0, exp1, acc0, acc1, pop;
      logic [W0-1:0] w0;
      logic [W1-1:0] w1;
      v0 = en0 && (src0Q.size() > 0);
      v1 = en1 && (src1Q.size() > 0);
      rst       = rstIn;
      din0Valid = v0;
      din0Data  = v0 ? src0Q[0] : W0'($urandom);
      din1Valid = v1;
      din1Data  = v1 ? src1Q[0] : W1'($urandom);
      doutReady = rdy;
      @(negedge clk);
      exp0 = !rstIn && (modelActive == 0) && (expQ.size() < 2);
      exp1 = !rstIn && (modelActive == 1) && (expQ.size() < 2);
      checkOutput("din0_ready", 32'(din0Ready), 32'(exp0));
      checkOutput("din1_ready", 32'(din1Ready), 32'(exp1));
      checkOutput("dout_valid", 32'(doutValid), 32'(expQ.size() > 0));
      if (expQ.size() > 0) begin
         checkOutput("dout_data", 32'(doutData), 32'(expQ[0]));
      end
      checkOutput("pair_cnt", 32'(pairCnt), 32'(modelPairs));
      if (rstIn) begin
         expQ.delete();
         modelActive = 0;
         modelPairs  = 0;
      end else begin
         acc0 = v0 && exp0;
         acc1 = v1 && exp1;
         pop  = (expQ.size() > 0) && rdy;
         if (pop) void'(expQ.pop_front());
         if (acc0) begin
            w0 = src0Q.pop_front();
            expQ.push_back({1'b0, w0[W0-1], 1'b0, WP'(w0[W0-2:0])});
            if (w0[W0-1]) modelActive = 1;
         end
         if (acc1) begin
            w1 = src1Q.pop_front();
            expQ.push_back({w1[W1-1], w1[W1-1], 1'b1, WP'(w1[W1-2:0])});
            if (w1[W1-1]) begin
               modelActive = 0;
               modelPairs  = (modelPairs + 1) % (1 << WC);
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic resetAll();
      src0Q.delete();
      src1Q.delete();
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      logic [W0-1:0] r0;
      logic [W1-1:0] r1;
      modelActive = 0;
      modelPairs  = 0;
      rst = 1'b1; din0Valid = 1'b0; din1Valid = 1'b0; din0Data = '0; din1Data = '0; doutReady = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);

      // Basic pair: three din0 beats, then two din1 beats.
      src0Q = '{8'h01, 8'h02, 8'h83};
      src1Q = '{16'h0004, 16'h8005};
      repeat (10) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("pair_cnt_first_pair", 32'(pairCnt), 32'd1);

      // din1 is held valid before its turn comes.
      src1Q = '{16'h8011};
      src0Q = '{8'h07, 8'h88};
      repeat (6) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

      // Back-pressure: dout stalls for five cycles, then releases.
      src0Q = '{8'h21, 8'h22, 8'h23, 8'hA4};
      src1Q = '{16'h8030};
      repeat (5) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (8) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

      // Seventeen single-beat pairs make the 4-bit counter wrap to 1.
      resetAll();
      for (int i = 0; i < 17; i++) begin
         src0Q.push_back(8'h81);
         src1Q.push_back(16'h8002);
      end
      repeat (40) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("pair_cnt_wrap", 32'(pairCnt), 32'd1);

      // Narrow din0: a payload of 0x7F is zero-extended.
      resetAll();
      src0Q = '{8'hFF};
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("zero_extend", 32'(doutData), 32'h1007F);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

      // Reset while beats are buffered; the next beat accepted is the first one emitted.
      resetAll();
      src0Q = '{8'h41, 8'h42, 8'hC3};
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("post_reset_valid", 32'(doutValid), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
      checkOutput("post_reset_first", 32'(doutData), 32'h10043);
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 2000; c++) begin
         if (src0Q.size() < 3) begin
            r0 = W0'($urandom);
            r0[W0-1] = ($urandom_range(3) == 0);
            src0Q.push_back(r0);
         end
         if (src1Q.size() < 3) begin
            r1 = W1'($urandom);
            r1[W1-1] = ($urandom_range(3) == 0);
            src1Q.push_back(r1);
         end
         applyStimulus($urandom_range(199) == 0, $urandom_range(3) != 0,
                       $urandom_range(3) != 0, $urandom_range(9) < 7);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/queue_pair_merge.md
QUEUE_PAIR_MERGE -- requirements
Module: queue_pair_merge

Interface
REQ-001 SHALL have parameter W_DIN0, default 16, meaning din0 data width (MSB = eot, low W_DIN0-1 bits = payload).
REQ-002 SHALL have parameter W_DIN1, default 16, meaning din1 data width (MSB = eot, low W_DIN1-1 bits = payload).
REQ-003 SHALL have parameter W_CNT, default 16, meaning width of the completed-pair counter.
REQ-004 SHALL define WP = max(W_DIN0,W_DIN1)-1 and W_DOUT = WP+3.
REQ-005 SHALL use one clock and a synchronous, active-high reset: clk input, 1 bit, rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 din0  dti.consumer  W_DIN0  first stream of each pair (data/valid/ready).
REQ-008 din1  dti.consumer  W_DIN1  second stream of each pair (data/valid/ready).
REQ-009 dout  dti.producer  W_DOUT  merged stream, data = {pair_eot, eot, src, payload[WP-1:0]}.
REQ-010 pair_cnt  output  W_CNT  number of completed pairs, modulo 2^W_CNT.

Function
REQ-011 SHALL hold a 2-state FSM: S0 (draining din0), S1 (draining din1).
REQ-012 In S0, SHALL drive din0.ready = !full and din1.ready = 0; in S1, din1.ready = !full and din0.ready = 0.
REQ-013 SHALL never accept from the inactive input, whatever its valid.
REQ-014 On accept with eot=1: S0 -> S1, S1 -> S0; accept with eot=0 stays.
REQ-015 Single-element transaction (first beat eot=1) SHALL switch state after that one beat.
REQ-016 Each accepted beat SHALL be written into a 2-entry FIFO as {pair_eot, eot, src, payload}.
REQ-017 src = 0 for din0 beats, 1 for din1 beats.
REQ-018 Payload SHALL be zero-extended to WP bits; no truncation.
REQ-019 pair_eot = 1 only on a din1 beat with eot=1; otherwise 0.
REQ-020 pair_cnt SHALL increment by 1 in the cycle after the din1 eot beat is accepted, wrapping from 2^W_CNT-1 to 0.
REQ-021 dout.valid = FIFO non-empty; dout.data = oldest entry; dout.valid and dout.data SHALL be driven from registers only.
REQ-022 Latency: beat accepted in cycle N SHALL be presented on dout in cycle N+1 if the FIFO was empty.
REQ-023 full = 2 entries stored; ready SHALL depend only on registered state, never combinationally on dout.ready.
REQ-024 Push and pop in the same cycle with 1 entry SHALL keep occupancy 1 and preserve order.
REQ-025 Pop with 2 entries (no push possible) SHALL leave 1 entry; the next cycle ready SHALL reassert.
REQ-026 dout.data SHALL remain stable while dout.valid=1 and dout.ready=0.
REQ-027 Sustained throughput SHALL be 1 beat/cycle when dout.ready is held high, including across S0/S1 switches.
REQ-028 Order SHALL be strictly preserved: the full din0 transaction, then the full din1 transaction, repeating.

Reset
REQ-029 On rst=1 at a clock edge: FSM = S0, FIFO empty, dout.valid = 0, pair_cnt = 0.
REQ-030 din0.ready and din1.ready SHALL be 0 during the reset cycle; after reset, din0.ready = 1.
REQ-031 Reset mid-transaction SHALL discard buffered beats and partial pair state; no beat SHALL be emitted from before reset.

Verification
REQ-032 W_DIN0=W_DIN1=16, dout.ready=1; din0 sends 0x0001,0x0002,0x8003, then din1 sends 0x0004,0x8005 -> dout in order: payloads 1,2,3 with src=0, eot only on 3; payloads 4,5 with src=1, eot+pair_eot on 5; pair_cnt 0->1 one cycle after the 0x8005 accept.
REQ-033 din1.valid held high from cycle 0 while din0 sends 0x0007,0x8008 -> din1.ready=0 until the 0x8008 accept, then din1 accepted from the next cycle; no din1 beat precedes payload 8 on dout.
REQ-034 dout.ready=0 for 5 cycles while din0 streams -> exactly 2 beats accepted, din0.ready=0 after the second, dout.data constant; on release, order intact and 1 beat/cycle resumes.
REQ-035 Single-beat pairs: din0 0x8001, din1 0x8002, repeated 2^W_CNT+1 times with W_CNT=4 -> 17 pairs emitted, pair_cnt wraps to 1.
REQ-036 W_DIN0=8, W_DIN1=16: din0 0xFF -> dout payload 0x007F, eot=1, src=0.
REQ-037 rst asserted after 2 of 3 din0 beats are accepted with dout.ready=0 -> dout.valid=0 and pair_cnt=0 the cycle after, FSM in S0, and the next din0 beat is emitted as the first output.
